// File: rtl/led_pwm_dimmer_pkg.sv
// led_pwm_dimmer_pkg: shared LED board constants and level-step decoding for the PWM dimmer.
package led_pwm_dimmer_pkg;
    localparam int LED_WIDTH = 16;
    localparam int LED_LEVEL_BITS = 4;
    localparam int LED_DEFAULT_LEVEL = 8;
    localparam int CLK_10MHZ_HZ = 10_000_000;
    localparam int LED_PWM_HZ = 1000;
    typedef enum logic [1:0] {STEP_HOLD, STEP_UP, STEP_DOWN} step_t;
    // Simultaneous up and down cancel out.
    function automatic step_t step_of(input logic up, input logic down);
        return (up && !down) ? STEP_UP : (down && !up) ? STEP_DOWN : STEP_HOLD;
    endfunction
endpackage

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: slot-rate prescaler and PWM slot counter; flags the last cycle of each frame.
module pwm_tick_gen #(
    parameter int CLK_HZ = 10_000_000,
    parameter int PWM_HZ = 1000,
    parameter int LEVEL_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  tick,
    output logic [LEVEL_BITS-1:0] slot,
    output logic                  boundary
);
    localparam int TICK_DIV = CLK_HZ / (PWM_HZ * (2 ** LEVEL_BITS));
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    if (TICK_DIV < 1) begin : g_bad_div
        $error("pwm_tick_gen: CLK_HZ too low for PWM_HZ * 2**LEVEL_BITS");
    end
    logic [PW-1:0] prescaler;
    assign tick = prescaler == TICK_LAST;
    assign boundary = tick && slot == '1;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
            slot <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) slot <= slot + 1'b1;
        end
    end
endmodule

// File: rtl/led_pwm_dimmer.sv
// led_pwm_dimmer: frame-sampled LED pattern gated by a 4-bit PWM level stepped with up/down pulses.
module led_pwm_dimmer
    import led_pwm_dimmer_pkg::*;
#(
    parameter int WIDTH = LED_WIDTH,
    parameter int CLK_HZ = CLK_10MHZ_HZ,
    parameter int PWM_HZ = LED_PWM_HZ,
    parameter int LEVEL_BITS = LED_LEVEL_BITS,
    parameter int DEFAULT_LEVEL = LED_DEFAULT_LEVEL
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      led_in,
    input  logic                  level_up,
    input  logic                  level_down,
    output logic [WIDTH-1:0]      led_out,
    output logic [LEVEL_BITS-1:0] level,
    output logic                  frame_start
);
    localparam logic [LEVEL_BITS-1:0] LEVEL_MAX = '1;
    localparam logic [LEVEL_BITS-1:0] LEVEL_DEF = LEVEL_BITS'(DEFAULT_LEVEL);
    logic                  tick;
    logic                  unused_tick;
    logic                  boundary;
    logic [LEVEL_BITS-1:0] slot;
    logic [LEVEL_BITS-1:0] pending;
    logic [LEVEL_BITS-1:0] pending_next;
    logic [WIDTH-1:0]      shadow;
    logic [WIDTH-1:0]      gated;
    step_t                 step;
    assign unused_tick = tick;
    pwm_tick_gen #(
        .CLK_HZ(CLK_HZ),
        .PWM_HZ(PWM_HZ),
        .LEVEL_BITS(LEVEL_BITS)
    ) u_tick_gen (
        .clk(clk),
        .reset_n(reset_n),
        .tick(tick),
        .slot(slot),
        .boundary(boundary)
    );
    assign step = step_of(level_up, level_down);
    always_comb begin
        pending_next = (step == STEP_UP && pending != LEVEL_MAX) ? pending + 1'b1 :
                       (step == STEP_DOWN && pending != '0) ? pending - 1'b1 : pending;
    end
    // Full level must light every slot, including slot MAX where slot<level fails.
    always_comb begin
        gated = (level == '0) ? '0 :
                (level == LEVEL_MAX || slot < level) ? shadow : '0;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= LEVEL_DEF;
            level <= LEVEL_DEF;
            shadow <= '0;
            led_out <= '0;
            frame_start <= 1'b0;
        end else begin
            pending <= pending_next;
            if (boundary) begin
                shadow <= led_in;
                level <= pending_next;
            end
            frame_start <= boundary;
            led_out <= gated;
        end
    end
endmodule

// File: tb/tb_led_pwm_dimmer.sv
// tb_led_pwm_dimmer: directed stimulus with a per-frame scoreboard checked on every frame_start.
module tb_led_pwm_dimmer;
    localparam int FRAME = 160;
    typedef struct {
        int lvl;
        int pat;
        int on;
    } exp_t;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] led_in = 16'hFFFF;
    logic        level_up = 1'b0;
    logic        level_down = 1'b0;
    logic [15:0] led_out;
    logic [3:0]  level;
    logic        frame_start;
    int          checks = 0;
    int          errors = 0;
    bit          rst_flag = 1'b0;
    exp_t        q[$];
    always #5 clk = ~clk;
    led_pwm_dimmer #(
        .WIDTH(16),
        .CLK_HZ(160),
        .PWM_HZ(1),
        .LEVEL_BITS(4),
        .DEFAULT_LEVEL(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .led_in(led_in),
        .level_up(level_up),
        .level_down(level_down),
        .led_out(led_out),
        .level(level),
        .frame_start(frame_start)
    );
    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask
    task automatic expect_frame(input int lvl, input int pat, input int on);
        exp_t e;
        e.lvl = lvl;
        e.pat = pat;
        e.on = on;
        q.push_back(e);
    endtask
    task automatic wait_fs(output int n);
        n = -1;
        for (int i = 1; i <= 2 * FRAME; i++) begin
            @(negedge clk);
            if (frame_start) begin
                n = i;
                break;
            end
        end
    endtask
    task automatic pulse(input logic up, input logic down);
        level_up = up;
        level_down = down;
        @(negedge clk);
        level_up = 1'b0;
        level_down = 1'b0;
        @(negedge clk);
    endtask
    // Each frame: led_out sampled on the 160 negedges after its frame_start is scored at the next one.
    initial begin : monitor
        exp_t cur;
        bit active = 1'b0;
        int samples = 0;
        int on_cnt = 0;
        int bad_cnt = 0;
        int cyc = 0;
        int last_fs = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_flag) begin
                active = 1'b0;
                last_fs = -1;
                rst_flag = 1'b0;
            end
            if (active) begin
                samples++;
                if (int'(led_out) == cur.pat) on_cnt++;
                else if (led_out != '0) bad_cnt++;
            end
            if (frame_start) begin
                if (active && samples == FRAME) begin
                    check("on_cycles", on_cnt, cur.on);
                    check("stray_led_out", bad_cnt, 0);
                end
                if (last_fs >= 0) check("frame_period", cyc - last_fs, FRAME);
                last_fs = cyc;
                if (q.size() == 0) begin
                    check("expected_frame_queued", 0, 1);
                    active = 1'b0;
                end else begin
                    cur = q.pop_front();
                    check("frame_level", int'(level), cur.lvl);
                    active = 1'b1;
                end
                samples = 0;
                on_cnt = 0;
                bad_cnt = 0;
            end
        end
    end
    initial begin : stimulus
        int n;
        repeat (3) @(negedge clk);
        check("rst_led_out", int'(led_out), 0);
        check("rst_level", int'(level), 8);
        check("rst_frame_start", int'(frame_start), 0);
        reset_n = 1'b1;
        led_in = 16'hA5A5;
        expect_frame(8, 16'hA5A5, 80);
        wait_fs(n);
        check("first_frame_start", n, 160);
        expect_frame(8, 16'hA5A5, 80);
        wait_fs(n);
        check("frame2_start", n, 160);
        repeat (20) @(negedge clk);
        repeat (10) pulse(1'b1, 1'b0);
        check("level_held_mid_frame", int'(level), 8);
        expect_frame(15, 16'hA5A5, 160);
        wait_fs(n);
        check("frame3_start", n, 120);
        repeat (20) @(negedge clk);
        repeat (20) pulse(1'b0, 1'b1);
        check("level_held_max", int'(level), 15);
        expect_frame(0, 16'hA5A5, 0);
        wait_fs(n);
        check("frame4_start", n, 100);
        repeat (20) @(negedge clk);
        pulse(1'b1, 1'b1);
        check("level_held_zero", int'(level), 0);
        repeat (3) pulse(1'b1, 1'b0);
        expect_frame(3, 16'hA5A5, 30);
        wait_fs(n);
        check("frame5_start", n, 132);
        led_in = 16'h00FF;
        expect_frame(4, 16'h00FF, 40);
        repeat (159) @(negedge clk);
        level_up = 1'b1;
        @(negedge clk);
        level_up = 1'b0;
        check("boundary_frame_start", int'(frame_start), 1);
        repeat (33) @(negedge clk);
        led_in = 16'hFF00;
        expect_frame(4, 16'hFF00, 40);
        wait_fs(n);
        check("frame7_start", n, 127);
        repeat (20) @(negedge clk);
        check("pre_reset_led_out", int'(led_out), 16'hFF00);
        #1 reset_n = 1'b0;
        rst_flag = 1'b1;
        #1;
        check("async_rst_led_out", int'(led_out), 0);
        check("async_rst_level", int'(level), 8);
        check("async_rst_frame_start", int'(frame_start), 0);
        reset_n = 1'b1;
        expect_frame(8, 16'hFF00, 80);
        wait_fs(n);
        check("restart_frame_start", n, 160);
        expect_frame(8, 16'hFF00, 80);
        wait_fs(n);
        check("frame9_start", n, 160);
        repeat (5) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
